muldiv_seq: RTL

Iterative, parametrised multiply/divide unit implementing the RV32M operation set, sitting beside the single-cycle `alu` in the execute stage. It accepts one operation per start pulse, computes it over a fixed number of cycles with a radix-2 shift-add or restoring-division datapath, and returns a held result with a one-cycle done strobe. The core stalls on `busy`.

---
 rtl/muldiv_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Fixed latency of WIDTH+2 cycles per operation; result is held until the next one completes.
module muldiv_seq #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;
    logic               sgn_x;
    logic               sgn_a;
    logic               div_zero;

    // Operand sign handling at accept: MULHSU treats only A as signed, unsigned ops neither.
    logic             a_sgn, b_sgn;
    logic [WIDTH-1:0] a_abs, b_abs;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (op)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_sgn = A[WIDTH-1];
                b_sgn = B[WIDTH-1];
            end
            3'b010:  a_sgn = A[WIDTH-1];
            default: ;
        endcase
        a_abs = a_sgn ? (~A + 1'b1) : A;
        b_abs = b_sgn ? (~B + 1'b1) : B;
    end

    // One iteration of each datapath; only the one matching op_q[2] is committed.
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;

    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
        div_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_val;

    always_comb begin
        prod_fix = sgn_x ? (~prod + 1'b1) : prod;
        quo_fix  = sgn_x ? (~quo + 1'b1) : quo;
        rem_fix  = sgn_a ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
        fix_val  = '0;
        case (op_q)
            3'b000:                 fix_val = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_val = div_zero ? '1 : quo_fix;
            default:                fix_val = div_zero ? a_q : rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            opnd     <= '0;
            prod     <= '0;
            rem      <= '0;
            quo      <= '0;
            sgn_x    <= 1'b0;
            sgn_a    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q     <= op;
                        a_q      <= A;
                        opnd     <= op[2] ? b_abs : a_abs;
                        prod     <= {{WIDTH{1'b0}}, b_abs};
                        quo      <= a_abs;
                        rem      <= '0;
                        sgn_x    <= a_sgn ^ b_sgn;
                        sgn_a    <= a_sgn;
                        div_zero <= (B == '0);
                        cnt      <= CNT_W'(WIDTH);
                        busy     <= 1'b1;
                        state    <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (op_q[2]) begin
                        if (!div_diff[WIDTH]) begin
                            rem <= div_diff;
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= div_shift;
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        prod <= {mul_sum, prod[WIDTH-1:1]};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result <= fix_val;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
